ponylink_serdes_gear: RTL
=========================

PONYLINK_SERDES_GEAR -- requirements
Module: ponylink_serdes_gear

Interface
REQ-001 SHALL have parameter PARBITS, default 4: bits per clk cycle on core and SERDES sides.
REQ-002 SHALL have parameter TRI_HOLD, default 3: clk cycles the driver stays enabled after the last enabled bit.
REQ-003 SHALL have parameter LOOP_LAT, default 2: clk cycles from oserdes_d launch until the same word appears on iserdes_q.
REQ-004 SHALL have parameter ERRCNT_WIDTH, default 8: collision counter width.
REQ-005 SHALL have one clock, clk; reset is resetn, asynchronous and active-low.
REQ-006 clk  input  1  system clock, equal to the SERDES CLKDIV.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 core_out  input  PARBITS  link-core transmit bits; bit 0 is earliest in time.
REQ-009 core_en  input  PARBITS  per-bit drive enable for core_out.
REQ-010 core_in  output  PARBITS  received bits to the link core; bit 0 is earliest.
REQ-011 oserdes_d  output  PARBITS  parallel data to the OSERDES; bit 0 is sent first.
REQ-012 oserdes_t  output  1  tristate to the OSERDES; 1 means released.
REQ-013 iserdes_q  input  PARBITS  parallel data from the ISERDES; bit 0 is earliest.
REQ-014 clear_count  input  1  synchronous clear of collision_count.
REQ-015 collision  output  1  one-cycle pulse on a driven-word mismatch.
REQ-016 collision_count  output  ERRCNT_WIDTH  saturating collision count.

Function
REQ-017 SHALL keep a hold-last register; each cycle, scan i=0..PARBITS-1 in ascending order: if core_en[i] then last=core_out[i], and oserdes_d[i] takes the current last.
REQ-018 oserdes_d SHALL be registered (1 cycle latency); last SHALL persist across cycles with no enables, so the line level never glitches between bursts.
REQ-019 SHALL load hold counter cnt with TRI_HOLD when |core_en; otherwise decrement cnt, saturating at 0.
REQ-020 oserdes_t SHALL be (cnt==0), so an enable in cycle n drives t=0 in cycles n+1..n+TRI_HOLD.
REQ-021 A new enable while cnt>0 SHALL reload TRI_HOLD, with no release gap.
REQ-022 core_in SHALL be iserdes_q registered once (1 cycle latency), with no reordering.
REQ-023 SHALL delay {oserdes_d, ~oserdes_t} by LOOP_LAT+1 cycles to form {exp_d, exp_v}.
REQ-024 When exp_v=1 and core_in!=exp_d, collision SHALL pulse high for that cycle; otherwise collision is 0.
REQ-025 collision_count SHALL increment on each collision and saturate at all-ones with no wrap.
REQ-026 clear_count SHALL set collision_count to 0 next cycle and take priority over a simultaneous collision; the collision pulse itself SHALL still assert.
REQ-027 Released words (exp_v=0) SHALL never be compared, covering turnaround and slave-driven traffic.

Reset
REQ-028 On resetn low, asynchronously: oserdes_d=0, last=0, cnt=0, oserdes_t=1, core_in=0, all exp_v stages=0, collision=0, collision_count=0.
REQ-029 Reset mid-burst SHALL release the line immediately; after deassertion no collision SHALL be flagged until LOOP_LAT+1 cycles after the first new enable.

Structure
REQ-030 Shared package ponylink_serdes_pkg SHALL hold the defaults for PARBITS, TRI_HOLD, LOOP_LAT and ERRCNT_WIDTH.
REQ-031 The expected-word pipeline SHALL be sub-module ponylink_serdes_delay, with parameters WIDTH and DEPTH, an asynchronous active-low reset, and reset value 0.
REQ-032 The block SHALL contain no SERDES or IOBUF primitives; those remain in the top level.

Verification
REQ-033 Scenario "hold-last": core_en=4'b0010, core_out=4'b0010 -> oserdes_d=4'b1100 next cycle; all-zero enables afterwards -> oserdes_d=4'b1111.
REQ-034 Scenario "tristate": single enable in cycle 10 -> oserdes_t=0 in cycles 11,12,13 and 1 in cycle 14; a second enable in cycle 12 -> t=0 through cycle 15.
REQ-035 Scenario "loopback clean": iserdes_q = oserdes_d delayed LOOP_LAT=2, 100 random bursts -> collision never asserts, collision_count=0.
REQ-036 Scenario "collision": force bit 2 of one looped-back driven word inverted -> exactly one collision pulse at launch cycle+3, collision_count=1.
REQ-037 Scenario "saturate and clear": 300 forced collisions -> collision_count=255; clear_count coincident with a collision -> collision_count=0 next cycle, collision=1.
REQ-038 Scenario "reset mid-burst": resetn low while cnt=2 -> oserdes_t=1 and oserdes_d=0 immediately, all outputs at reset values, no collision after release.

Source files
------------

// File: rtl/ponylink_serdes_pkg.sv
// Shared defaults and helpers for the PonyLink SERDES gearbox.
package ponylink_serdes_pkg;

  localparam int DEF_PARBITS      = 4;
  localparam int DEF_TRI_HOLD     = 3;
  localparam int DEF_LOOP_LAT     = 2;
  localparam int DEF_ERRCNT_WIDTH = 8;

  // Width of a counter that must hold values 0..hold (at least one bit).
  function automatic int hold_cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/ponylink_serdes_delay.sv
// Fixed-depth shift pipeline with async active-low reset; carries the
// launched word and its drive-valid flag until the loopback copy returns.
module ponylink_serdes_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: unlike a plain data store, every stage is reset: the valid bit
      // rides in here and a stale 1 after reset would raise false collisions.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ponylink_serdes_gear.sv
// PonyLink SERDES gearbox: hold-last transmit shaping, tristate hold timer,
// receive register and loopback collision detection against driven words.
module ponylink_serdes_gear
  import ponylink_serdes_pkg::*;
#(
  parameter int PARBITS      = DEF_PARBITS,
  parameter int TRI_HOLD     = DEF_TRI_HOLD,
  parameter int LOOP_LAT     = DEF_LOOP_LAT,
  parameter int ERRCNT_WIDTH = DEF_ERRCNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [PARBITS-1:0]      core_out,
  input  logic [PARBITS-1:0]      core_en,
  output logic [PARBITS-1:0]      core_in,
  output logic [PARBITS-1:0]      oserdes_d,
  output logic                    oserdes_t,
  input  logic [PARBITS-1:0]      iserdes_q,
  input  logic                    clear_count,
  output logic                    collision,
  output logic [ERRCNT_WIDTH-1:0] collision_count
);

  localparam int               CNT_W     = hold_cnt_width(TRI_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(TRI_HOLD);

  logic [PARBITS-1:0]      d_q, d_d;
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    t_q;
  logic [PARBITS-1:0]      core_in_q;
  logic [ERRCNT_WIDTH-1:0] count_q, count_d;

  logic [PARBITS:0]        exp_word;
  logic [PARBITS-1:0]      exp_d;
  logic                    exp_v;
  logic                    collision_w;

  // Each bit carries the level held before its own enable is applied, so the
  // line never changes level except where the core asked for it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned (no latch); blocking '=' lets last_d ripple across
    // the bit scan within one cycle, while always_ff blocks use '<=' only.
    last_d = last_q;
    d_d    = '0;
    for (int i = 0; i < PARBITS; i++) begin
      d_d[i] = last_d;
      if (core_en[i]) last_d = core_out[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|core_en)            cnt_d = HOLD_LOAD;
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    count_d = count_q;
    if (clear_count)                         count_d = '0;
    else if (collision_w && count_q != '1)   count_d = count_q + ERRCNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q       <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      t_q       <= 1'b1;
      core_in_q <= '0;
      count_q   <= '0;
    end else begin
      d_q       <= d_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      t_q       <= (cnt_d == '0);
      core_in_q <= iserdes_q;
      count_q   <= count_d;
    end
  end

  // One extra stage beyond the loop latency matches the core_in register.
  ponylink_serdes_delay #(
    .WIDTH (PARBITS + 1),
    .DEPTH (LOOP_LAT + 1)
  ) u_exp_delay (
    .clk    (clk),
    .resetn (resetn),
    .din_i  ({d_q, ~t_q}),
    .dout_o (exp_word)
  );

  assign exp_d = exp_word[PARBITS:1];
  assign exp_v = exp_word[0];

  // Released words are never compared: turnaround and slave traffic pass.
  assign collision_w = exp_v && (core_in_q != exp_d);

  assign oserdes_d       = d_q;
  assign oserdes_t       = t_q;
  assign core_in         = core_in_q;
  assign collision       = collision_w;
  assign collision_count = count_q;

endmodule
